tero_response_collector: RTL and testbench
==========================================

// Module: tero_response_collector
//
// PURPOSE
//  Receiving end of the TERO evaluation FSM's result interface. Captures the accumulated oscillation count
//  on each one-cycle store_response_puf strobe and normalises it to a per-loop average. On fsm_done it
//  compares loops pairwise into an NUM_LOOPS/2-bit PUF response, delivered with a valid/ready handshake.
//  Sits between the shared TERO counter/FSM and the response transport (e.g. UART framer).
//
// PARAMETERS
//  NUM_LOOPS         4   number of TERO loops; must be even and >= 2
//  COUNT_BITS        32  width of the shared oscillation counter
//  REPETITIONS_BITS  13  same value as the FSM; average = count >> (REPETITIONS_BITS-1)
//  AVG_BITS          16  width of each stored average; larger shifted values saturate
//
// PORTS
//  clk                 in   1                    global clock
//  reset               in   1                    asynchronous, active-low reset
//  start               in   1                    same start the FSM sees; rising edge begins a new challenge
//  store_response_puf  in   1                    one-cycle strobe: osc_count/select_puf are valid this cycle only
//  select_puf          in   $clog2(NUM_LOOPS)    index of the loop being stored
//  osc_count           in   COUNT_BITS           shared counter value (REPETITIONS * F_i)
//  fsm_done            in   1                    FSM done level; rising edge triggers comparison
//  response            out  NUM_LOOPS/2          response bit k = (avg[2k] > avg[2k+1])
//  response_valid      out  1                    response word (and response_error) valid
//  response_ready      in   1                    downstream accepts when valid && ready
//  response_error      out  1                    >=1 loop not stored for this challenge, or >=1 tie
//  busy                out  1                    high in every state except IDLE
//
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; response=0, response_valid=0, response_error=0, busy=0;
//    valid bitmap cleared. Averages need not be cleared. Reset mid-operation aborts without emitting a word.
//  - States:
//    IDLE:     start rising edge -> clear bitmap and error -> COLLECT.
//    COLLECT:  on store_response_puf, avg[select_puf] <= sat(osc_count >> (REPETITIONS_BITS-1)), bitmap bit set
//              (captured on the same clock edge as the strobe). Repeated index overwrites.
//              fsm_done rising edge -> k=0 -> COMPARE.
//    COMPARE:  one pair per cycle. response[k] <= avg[2k] > avg[2k+1]; ties give 0 and set error.
//              After k = NUM_LOOPS/2-1 -> OUTPUT. Latency from fsm_done edge to response_valid is
//              NUM_LOOPS/2+1 cycles.
//    OUTPUT:   response_valid=1; response and response_error stable until accepted.
//              valid && ready -> IDLE next cycle, valid deasserted.
//  - response_error is the OR of: any bitmap bit clear at the fsm_done edge; any tie during COMPARE.
//  - Saturation: if the shifted count exceeds 2^AVG_BITS-1, store all-ones. No error is raised.
//  - Edge detection: start and fsm_done are registered; act on 0->1 only.
//    A start edge outside IDLE is ignored. fsm_done outside COLLECT is ignored.
//  - Strobes outside COLLECT are dropped. A strobe in the same cycle as the fsm_done edge is still stored,
//    and the bitmap check includes it.
//  - select_puf >= NUM_LOOPS is ignored, and the loop it would address stays unset.
//
// STRUCTURE
//  - tero_pkg: state enum (IDLE, COLLECT, COMPARE, OUTPUT); function sat_shift(); SEL_BITS = $clog2(NUM_LOOPS).
//  - Sub-module tero_avg_store: NUM_LOOPS x AVG_BITS register file with one write port (idx, data, we)
//    and two combinational read ports (2k, 2k+1), plus the valid bitmap and its clear input.
//  - Top level: edge detectors, FSM, pair counter k, response shift/assign register, handshake.
//
// TESTING
//  1. NUM_LOOPS=4, store counts [4096*100, 4096*50, 4096*30, 4096*70] then fsm_done
//     -> averages [100, 50, 30, 70]; response=2'b01, error=0; valid exactly 3 cycles after the edge.
//  2. Store only loops 0, 1, 2, then fsm_done -> response_valid=1, response_error=1.
//  3. avg[2]==avg[3]==42 -> response[1]=0, response_error=1.
//  4. osc_count=32'hFFFF_FFFF with AVG_BITS=16 -> stored 16'hFFFF; with other loop 0 the response bit is 1.
//  5. Hold response_ready=0 for 10 cycles in OUTPUT -> valid and response stable; ready=1 -> back to IDLE,
//     busy=0 the next cycle.
//  6. Assert reset=0 mid-COMPARE -> outputs 0 immediately. New start with all 4 loops stored
//     -> a correct word with no stale bits.

Source files
------------

// File: rtl/tero_pkg.sv
// Shared types and helpers for the TERO response collector.
package tero_pkg;

    // Collector control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        OUTPUT  = 2'd3
    } tero_state_t;

    // Default loop count and the matching loop-select width.
    localparam int DEFAULT_NUM_LOOPS = 4;
    localparam int SEL_BITS          = $clog2(DEFAULT_NUM_LOOPS);

    // Divide an accumulated count by the repetition count and clamp it to avgBits.
    function automatic logic [63:0] sat_shift(input logic [63:0] count,
                                              input int          shift,
                                              input int          avgBits);
        logic [63:0] shifted;
        logic [63:0] maxVal;
        shifted = count >> shift;
        maxVal  = (avgBits >= 64) ? '1 : ((64'd1 << avgBits) - 64'd1);
        return (shifted > maxVal) ? maxVal : shifted;
    endfunction

endpackage

// File: rtl/tero_avg_store.sv
// Per-loop average register file with a single write port, a pair read port
// and a bitmap recording which loops were written since the last clear.
module tero_avg_store
    import tero_pkg::*;
#(
    parameter int NUM_LOOPS = DEFAULT_NUM_LOOPS,
    parameter int AVG_BITS  = 16,
    parameter int SEL_BITS  = $clog2(NUM_LOOPS),
    parameter int PAIR_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 wrEn_i,
    input  logic [SEL_BITS-1:0]  wrIdx_i,
    input  logic [AVG_BITS-1:0]  wrData_i,
    input  logic [PAIR_BITS-1:0] rdPair_i,
    output logic [AVG_BITS-1:0]  rdDataA_o,
    output logic [AVG_BITS-1:0]  rdDataB_o,
    output logic [NUM_LOOPS-1:0] validNext_o
);

    logic [AVG_BITS-1:0]  avg_q [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] valid_q;
    logic [NUM_LOOPS-1:0] valid_d;
    logic [NUM_LOOPS-1:0] wrMask;
    logic [SEL_BITS-1:0]  rdIdxA;
    logic [SEL_BITS-1:0]  rdIdxB;

    // Decode the write index; indices with no matching loop produce an empty mask.
    always_comb begin
        wrMask = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (wrEn_i && (wrIdx_i == SEL_BITS'(i))) begin
                wrMask[i] = 1'b1;
            end
        end
    end

    // Next bitmap includes this cycle's write so a same-cycle check sees it.
    always_comb begin
        valid_d = (clear_i ? '0 : valid_q) | wrMask;
    end

    // Bitmap register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Average storage; contents are only trusted where the bitmap says so.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (wrMask[i]) begin
                avg_q[i] <= wrData_i;
            end
        end
    end

    assign rdIdxA      = SEL_BITS'({rdPair_i, 1'b0});
    assign rdIdxB      = SEL_BITS'({rdPair_i, 1'b1});
    assign rdDataA_o   = avg_q[rdIdxA];
    assign rdDataB_o   = avg_q[rdIdxB];
    assign validNext_o = valid_d;

endmodule

// File: rtl/tero_response_collector.sv
// Collects per-loop TERO oscillation counts, averages them, and compares
// loops pairwise into a PUF response word offered on a valid/ready port.
module tero_response_collector
    import tero_pkg::*;
#(
    parameter int NUM_LOOPS        = DEFAULT_NUM_LOOPS,
    parameter int COUNT_BITS       = 32,
    parameter int REPETITIONS_BITS = 13,
    parameter int AVG_BITS         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         store_response_puf,
    input  logic [$clog2(NUM_LOOPS)-1:0] select_puf,
    input  logic [COUNT_BITS-1:0]        osc_count,
    input  logic                         fsm_done,
    output logic [NUM_LOOPS/2-1:0]       response,
    output logic                         response_valid,
    input  logic                         response_ready,
    output logic                         response_error,
    output logic                         busy
);

    localparam int SelBits  = $clog2(NUM_LOOPS);
    localparam int NumPairs = NUM_LOOPS / 2;
    localparam int PairBits = (NumPairs > 1) ? $clog2(NumPairs) : 1;
    localparam logic [PairBits-1:0] LastPair = PairBits'(NumPairs - 1);

    tero_state_t           state_q, state_d;
    logic [PairBits-1:0]   k_q, k_d;
    logic [NumPairs-1:0]   response_q, response_d;
    logic                  error_q, error_d;
    logic                  startPrev_q;
    logic                  donePrev_q;

    logic                  startEdge;
    logic                  doneEdge;
    logic                  wrEn;
    logic                  clearBitmap;
    logic [AVG_BITS-1:0]   wrData;
    logic [AVG_BITS-1:0]   rdDataA;
    logic [AVG_BITS-1:0]   rdDataB;
    logic [NUM_LOOPS-1:0]  validNext;

    assign startEdge = start & ~startPrev_q;
    assign doneEdge  = fsm_done & ~donePrev_q;
    assign wrEn      = store_response_puf && (state_q == COLLECT);
    assign wrData    = AVG_BITS'(sat_shift(64'(osc_count), REPETITIONS_BITS - 1, AVG_BITS));

    tero_avg_store #(
        .NUM_LOOPS (NUM_LOOPS),
        .AVG_BITS  (AVG_BITS),
        .SEL_BITS  (SelBits),
        .PAIR_BITS (PairBits)
    ) u_avg_store (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clear_i     (clearBitmap),
        .wrEn_i      (wrEn),
        .wrIdx_i     (select_puf),
        .wrData_i    (wrData),
        .rdPair_i    (k_q),
        .rdDataA_o   (rdDataA),
        .rdDataB_o   (rdDataB),
        .validNext_o (validNext)
    );

    // Remember the previous level of start and fsm_done so only 0->1 transitions act.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startPrev_q <= 1'b0;
            donePrev_q  <= 1'b0;
        end else begin
            startPrev_q <= start;
            donePrev_q  <= fsm_done;
        end
    end

    // State, pair counter and response word registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            response_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            response_q <= response_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: collect averages, compare one pair per cycle, then hold the word until accepted.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        response_d  = response_q;
        error_d     = error_q;
        clearBitmap = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    clearBitmap = 1'b1;
                    error_d     = 1'b0;
                    response_d  = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (doneEdge) begin
                    k_d = '0;
                    if (!(&validNext)) begin
                        error_d = 1'b1;
                    end
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                for (int i = 0; i < NumPairs; i++) begin
                    if (k_q == PairBits'(i)) begin
                        response_d[i] = (rdDataA > rdDataB);
                    end
                end
                if (rdDataA == rdDataB) begin
                    error_d = 1'b1;
                end
                if (k_q == LastPair) begin
                    state_d = OUTPUT;
                end else begin
                    k_d = k_q + PairBits'(1);
                end
            end
            OUTPUT: begin
                if (response_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign response       = response_q;
    assign response_valid = (state_q == OUTPUT);
    assign response_error = error_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_tero_response_collector.sv
// Directed bench for tero_response_collector: a table of full challenges
// followed by hand-written sequences for handshake, edge and reset corners.
module tb_tero_response_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        store_response_puf = 1'b0;
    logic [1:0]  select_puf = 2'd0;
    logic [31:0] osc_count = 32'd0;
    logic        fsm_done = 1'b0;
    logic [1:0]  response;
    logic        response_valid;
    logic        response_ready = 1'b0;
    logic        response_error;
    logic        busy;

    int numVectors = 0;
    int numMiscompares = 0;

    typedef struct {
        logic [3:0][31:0] cnt;
        logic [3:0]       mask;
        logic [1:0]       expResp;
        logic             expErr;
        logic             chkResp;
    } tvec_t;

    tvec_t vecs[7];

    tero_response_collector dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .store_response_puf (store_response_puf),
        .select_puf         (select_puf),
        .osc_count          (osc_count),
        .fsm_done           (fsm_done),
        .response           (response),
        .response_valid     (response_valid),
        .response_ready     (response_ready),
        .response_error     (response_error),
        .busy               (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic tvec_t mkVec(input logic [31:0] c0, input logic [31:0] c1,
                                    input logic [31:0] c2, input logic [31:0] c3,
                                    input logic [3:0] mask, input logic [1:0] resp,
                                    input logic err, input logic chk);
        tvec_t v;
        v.cnt[0]  = c0;
        v.cnt[1]  = c1;
        v.cnt[2]  = c2;
        v.cnt[3]  = c3;
        v.mask    = mask;
        v.expResp = resp;
        v.expErr  = err;
        v.chkResp = chk;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic storeLoop(input logic [1:0] idx, input logic [31:0] cnt);
        @(negedge clk);
        store_response_puf = 1'b1;
        select_puf         = idx;
        osc_count          = cnt;
        @(negedge clk);
        store_response_puf = 1'b0;
        osc_count          = 32'd0;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Start a challenge, store the masked loops, then raise fsm_done at a negedge.
    task automatic applyStimulus(input logic [3:0][31:0] cnt, input logic [3:0] mask);
        pulseStart();
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) storeLoop(2'(i), cnt[i]);
        end
        @(negedge clk);
        fsm_done = 1'b1;
    endtask

    // Count rising edges until response_valid appears, bounded.
    task automatic waitValid(input string name, output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (response_valid) break;
        end
        if (!response_valid) begin
            numVectors++;
            numMiscompares++;
            $display("[TB] FAIL %s.timeout: got valid=0 after %0d cycles, expected valid=1", name, cycles);
        end
    endtask

    task automatic acceptWord();
        @(negedge clk);
        response_ready = 1'b1;
        fsm_done       = 1'b0;
        @(posedge clk);
        #1;
        response_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        logic [3:0][31:0] c;

        vecs[0] = mkVec(32'(4096*100), 32'(4096*50), 32'(4096*30), 32'(4096*70), 4'b1111, 2'b01, 1'b0, 1'b1);
        vecs[1] = mkVec(32'(4096*100), 32'(4096*50), 32'(4096*30), 32'(4096*70), 4'b0111, 2'b00, 1'b1, 1'b0);
        vecs[2] = mkVec(32'(4096*10),  32'(4096*5),  32'(4096*42), 32'(4096*42), 4'b1111, 2'b01, 1'b1, 1'b1);
        vecs[3] = mkVec(32'hFFFF_FFFF, 32'd0,        32'(4096*5),  32'(4096*3),  4'b1111, 2'b11, 1'b0, 1'b1);
        vecs[4] = mkVec(32'd0,         32'(4096*7),  32'(4096*9),  32'(4096*9+4095), 4'b1111, 2'b00, 1'b1, 1'b1);
        vecs[5] = mkVec(32'h0FFF_F000, 32'h1000_0000, 32'd4096,    32'd4095,     4'b1111, 2'b10, 1'b1, 1'b1);
        vecs[6] = mkVec(32'(4096*3),   32'(4096*8),  32'(4096*200), 32'(4096*199), 4'b1111, 2'b10, 1'b0, 1'b1);

        // Reset state
        #2 reset = 1'b0;
        #1;
        checkOutput("reset.valid", 32'(response_valid), 32'd0);
        checkOutput("reset.resp",  32'(response),       32'd0);
        checkOutput("reset.err",   32'(response_error), 32'd0);
        checkOutput("reset.busy",  32'(busy),           32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table of complete challenges
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].cnt, vecs[v].mask);
            waitValid($sformatf("vec%0d", v), cycles);
            checkOutput($sformatf("vec%0d.latency", v), 32'(cycles), 32'd3);
            if (vecs[v].chkResp) checkOutput($sformatf("vec%0d.resp", v), 32'(response), 32'(vecs[v].expResp));
            checkOutput($sformatf("vec%0d.err", v), 32'(response_error), 32'(vecs[v].expErr));
            acceptWord();
            checkOutput($sformatf("vec%0d.busyAfter", v), 32'(busy), 32'd0);
        end

        // Backpressure: word must hold while ready is low
        c = '{32'(4096*70), 32'(4096*30), 32'(4096*50), 32'(4096*100)};
        applyStimulus(c, 4'b1111);
        waitValid("hold", cycles);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d.valid", i), 32'(response_valid), 32'd1);
            checkOutput($sformatf("hold%0d.resp", i),  32'(response),       32'd1);
        end
        acceptWord();
        checkOutput("hold.validAfter", 32'(response_valid), 32'd0);
        checkOutput("hold.busyAfter",  32'(busy),           32'd0);

        // fsm_done while idle must not start a comparison
        @(negedge clk);
        fsm_done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idleDone.busy",  32'(busy),           32'd0);
        checkOutput("idleDone.valid", 32'(response_valid), 32'd0);
        @(negedge clk);
        fsm_done = 1'b0;

        // Second start edge while collecting must not clear the bitmap
        pulseStart();
        storeLoop(2'd0, 32'(4096*2));
        storeLoop(2'd1, 32'(4096*1));
        storeLoop(2'd2, 32'(4096*1));
        storeLoop(2'd3, 32'(4096*2));
        pulseStart();
        @(negedge clk);
        fsm_done = 1'b1;
        waitValid("restart", cycles);
        checkOutput("restart.resp", 32'(response),       32'd1);
        checkOutput("restart.err",  32'(response_error), 32'd0);
        acceptWord();

        // Last strobe coincides with the fsm_done rising edge
        pulseStart();
        storeLoop(2'd0, 32'(4096*5));
        storeLoop(2'd1, 32'(4096*9));
        storeLoop(2'd2, 32'(4096*7));
        @(negedge clk);
        store_response_puf = 1'b1;
        select_puf         = 2'd3;
        osc_count          = 32'(4096*3);
        fsm_done           = 1'b1;
        @(negedge clk);
        store_response_puf = 1'b0;
        osc_count          = 32'd0;
        waitValid("sameCycle", cycles);
        checkOutput("sameCycle.latency", 32'(cycles + 1), 32'd3);
        checkOutput("sameCycle.resp",    32'(response),       32'd2);
        checkOutput("sameCycle.err",     32'(response_error), 32'd0);
        acceptWord();

        // Reset in the middle of COMPARE aborts immediately
        c = '{32'(4096*70), 32'(4096*30), 32'(4096*50), 32'(4096*100)};
        applyStimulus(c, 4'b1111);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midReset.valid", 32'(response_valid), 32'd0);
        checkOutput("midReset.resp",  32'(response),       32'd0);
        checkOutput("midReset.err",   32'(response_error), 32'd0);
        checkOutput("midReset.busy",  32'(busy),           32'd0);
        @(negedge clk);
        reset    = 1'b1;
        fsm_done = 1'b0;
        c = '{32'(4096*3), 32'(4096*9), 32'(4096*2), 32'(4096*1)};
        applyStimulus(c, 4'b1111);
        waitValid("recover", cycles);
        checkOutput("recover.resp", 32'(response),       32'd2);
        checkOutput("recover.err",  32'(response_error), 32'd0);
        acceptWord();

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
